// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the MiniAlu multiply sequencer: FSM state encodings and default width.
package mul_sequencer_pkg;

    localparam int MUL_WIDTH = 16;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_LOAD = 2'd1,
        MUL_RUN  = 2'd2,
        MUL_DONE = 2'd3
    } mulState_t;

endpackage

// File: rtl/mul_sequencer_ffd.sv
// Rising-edge register with synchronous active-high reset and load enable.
module mul_sequencer_ffd #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    always_ff @(posedge Clock) begin
        if (Reset)
            Q <= '0;
        else if (Enable)
            Q <= D;
    end

endmodule

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add multiplier sequencer: start/busy/done handshake plus pipeline stall.
// Fixed latency WIDTH+2 cycles from the iStart edge to the oDone pulse; iStart is ignored outside IDLE.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iStart,
    input  logic               iSigned,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    output logic               oBusy,
    output logic               oStall,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oResult
);

    localparam int CNT_W = $clog2(WIDTH);

    mulState_t          state;
    logic [WIDTH-1:0]   opA, opB, magA, magB;
    logic               opSigned, neg;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   count;

    logic [WIDTH:0]     runSum;
    logic [2*WIDTH-1:0] runAcc;
    logic [2*WIDTH-1:0] resultD;
    logic               lastIter;

    // One iteration: add into the upper half with carry, then shift {carry, acc} right by one.
    assign runSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (magB[0] ? {1'b0, magA} : '0);
    assign runAcc   = {runSum, acc[WIDTH-1:1]};
    assign lastIter = (state == MUL_RUN) && (count == CNT_W'(WIDTH-1));
    assign resultD  = neg ? (~runAcc + (2*WIDTH)'(1)) : runAcc;

    assign oStall = (iStart && (state == MUL_IDLE)) || (state == MUL_LOAD) || (state == MUL_RUN);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= MUL_IDLE;
            oBusy    <= 1'b0;
            oDone    <= 1'b0;
            opA      <= '0;
            opB      <= '0;
            opSigned <= 1'b0;
            magA     <= '0;
            magB     <= '0;
            neg      <= 1'b0;
            acc      <= '0;
            count    <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    oDone <= 1'b0;
                    if (iStart) begin
                        opA      <= iA;
                        opB      <= iB;
                        opSigned <= iSigned;
                        oBusy    <= 1'b1;
                        state    <= MUL_LOAD;
                    end
                end
                MUL_LOAD: begin
                    // Most-negative value negates to itself, which reads correctly as an unsigned magnitude.
                    magA  <= (opSigned && opA[WIDTH-1]) ? (~opA + WIDTH'(1)) : opA;
                    magB  <= (opSigned && opB[WIDTH-1]) ? (~opB + WIDTH'(1)) : opB;
                    neg   <= opSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
                    acc   <= '0;
                    count <= '0;
                    state <= MUL_RUN;
                end
                MUL_RUN: begin
                    acc   <= runAcc;
                    magB  <= {1'b0, magB[WIDTH-1:1]};
                    count <= count + CNT_W'(1);
                    if (lastIter) begin
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                        state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    oDone <= 1'b0;
                    state <= MUL_IDLE;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

    // Loaded on the edge that enters DONE so the product is visible alongside oDone.
    mul_sequencer_ffd #(
        .WIDTH (2*WIDTH)
    ) resultReg (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (lastIter),
        .D      (resultD),
        .Q      (oResult)
    );

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: latency, stall window, signed/unsigned products, restart and reset abort.
module tb_mul_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic        iSigned;
    logic [15:0] iA, iB;
    logic        oBusy, oStall, oDone;
    logic [31:0] oResult;

    int tests = 0;
    int fails = 0;

    mul_sequencer #(.WIDTH(16)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iA      (iA),
        .iB      (iB),
        .oBusy   (oBusy),
        .oStall  (oStall),
        .oDone   (oDone),
        .oResult (oResult)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Entered 1 time unit after a rising edge with the DUT in IDLE.
    task automatic doMul(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] exp, input logic [31:0] prev, input string tag);
        iA = a; iB = b; iSigned = s; iStart = 1'b1;
        #1;
        check({tag, " stall c0"}, 32'(oStall), 32'd1);
        check({tag, " busy c0"}, 32'(oBusy), 32'd0);
        tick();
        iStart = 1'b0; iA = ~a; iB = ~b; iSigned = ~s;
        for (int c = 1; c <= 18; c++) begin
            check($sformatf("%s done c%0d", tag, c), 32'(oDone), 32'(c == 18));
            check($sformatf("%s stall c%0d", tag, c), 32'(oStall), 32'(c <= 17));
            if (c == 1 || c == 17) begin
                check($sformatf("%s busy c%0d", tag, c), 32'(oBusy), 32'd1);
                check($sformatf("%s held c%0d", tag, c), oResult, prev);
            end
            if (c == 18) begin
                check({tag, " busy done"}, 32'(oBusy), 32'd0);
                check({tag, " result"}, oResult, exp);
            end
            tick();
        end
        check({tag, " done after"}, 32'(oDone), 32'd0);
        check({tag, " result held"}, oResult, exp);
    endtask

    initial begin
        Reset = 1'b1; iStart = 1'b0; iSigned = 1'b0; iA = '0; iB = '0;
        tick(); tick();
        check("rst busy", 32'(oBusy), 32'd0);
        check("rst done", 32'(oDone), 32'd0);
        check("rst result", oResult, 32'd0);
        check("rst stall idle", 32'(oStall), 32'd0);
        // Reset and iStart together: Reset wins.
        iStart = 1'b1; iA = 16'd7; iB = 16'd7;
        #1;
        check("rst stall start", 32'(oStall), 32'd1);
        tick();
        check("rst+start busy", 32'(oBusy), 32'd0);
        Reset = 1'b0; iStart = 1'b0;
        tick();
        check("post rst busy", 32'(oBusy), 32'd0);
        check("post rst stall", 32'(oStall), 32'd0);

        doMul(16'h0003, 16'h0005, 1'b0, 32'h0000000F, 32'h00000000, "u3x5");
        doMul(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 32'h0000000F, "s-3x5");
        doMul(16'h8000, 16'h8000, 1'b1, 32'h40000000, 32'hFFFFFFF1, "sminxmin");
        doMul(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 32'h40000000, "umax");
        doMul(16'h0005, 16'hFFFF, 1'b1, 32'hFFFFFFFB, 32'hFFFE0001, "s5x-1");

        // Back-to-back: 7x9, then iStart held with 2x2 throughout.
        iA = 16'd7; iB = 16'd9; iSigned = 1'b0; iStart = 1'b1;
        tick();
        iA = 16'd2; iB = 16'd2;
        for (int c = 1; c <= 37; c++) begin
            check($sformatf("b2b done c%0d", c), 32'(oDone), 32'(c == 18 || c == 37));
            check($sformatf("b2b stall c%0d", c), 32'(oStall), 32'(c != 18 && c != 37));
            if (c == 18) check("b2b first", oResult, 32'h0000003F);
            if (c == 37) check("b2b second", oResult, 32'h00000004);
            if (c == 37) iStart = 1'b0;
            tick();
        end
        for (int c = 0; c < 20; c++) begin
            check($sformatf("b2b quiet c%0d", c), 32'(oDone), 32'd0);
            tick();
        end

        doMul(16'h0000, 16'hABCD, 1'b0, 32'h00000000, 32'h00000004, "zero");
        doMul(16'h0006, 16'h0007, 1'b0, 32'h0000002A, 32'h00000000, "u6x7");

        // Reset during RUN iteration 8 (cycle 10 after the start edge).
        iA = 16'h1234; iB = 16'h0010; iSigned = 1'b0; iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("abort busy before", 32'(oBusy), 32'd1);
        check("abort held before", oResult, 32'h0000002A);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort result", oResult, 32'd0);
        check("abort busy", 32'(oBusy), 32'd0);
        check("abort stall", 32'(oStall), 32'd0);
        for (int c = 0; c < 25; c++) begin
            check($sformatf("abort no done c%0d", c), 32'(oDone), 32'd0);
            tick();
        end
        check("abort result idle", oResult, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
